// File: rtl/d_flip_flop_sr_latch_pkg.sv
// d_flip_flop_sr_latch_pkg: shared sizing limits and latch reset-state constants
package d_flip_flop_sr_latch_pkg;
    localparam int   NUM_LATCHES_DEF = 8;
    localparam int   NUM_LATCHES_MAX = 32;
    localparam logic Q_RST           = 1'b0;
    localparam logic QN_RST          = 1'b1;
endpackage

// File: rtl/d_flip_flop_sr_latch_sr.sv
// sr_latch_cell: one NOR-type SR latch with a level-sensitive reset override
module sr_latch_cell
    import d_flip_flop_sr_latch_pkg::*;
(
    input  logic s,
    input  logic r,
    input  logic rst,
    output logic q,
    output logic qn
);
    logic state;
    // Only the settled q is stored, so leaving s=r=1 lands on the reset side.
    always_latch begin
        if (rst)
            state <= Q_RST;
        else if (s | r)
            state <= s & ~r;
    end
    assign q  = rst ? Q_RST  : (~r & (s | state));
    assign qn = rst ? QN_RST : (~s & (r | ~state));
endmodule

// File: rtl/d_flip_flop_sr_latch.sv
// d_flip_flop_sr_latch: SR latch array plus registered data bit and latch parity
module d_flip_flop_sr_latch
    import d_flip_flop_sr_latch_pkg::*;
#(
    parameter int NUM_LATCHES = NUM_LATCHES_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_LATCHES-1:0] s,
    input  logic [NUM_LATCHES-1:0] r,
    input  logic                   d,
    output logic [NUM_LATCHES-1:0] q,
    output logic [NUM_LATCHES-1:0] qn,
    output logic                   dff_q,
    output logic                   parity_q
);
    logic [NUM_LATCHES_MAX-1:0] q_ext;
    for (genvar i = 0; i < NUM_LATCHES; i++) begin : g_latch
        sr_latch_cell u_cell (
            .s   (s[i]),
            .r   (r[i]),
            .rst (reset),
            .q   (q[i]),
            .qn  (qn[i])
        );
    end
    assign q_ext = NUM_LATCHES_MAX'(q);
    always_ff @(posedge clk) begin
        if (reset) begin
            dff_q    <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            dff_q    <= d;
            parity_q <= ^q_ext;
        end
    end
endmodule

// File: tb/tb_d_flip_flop_sr_latch.sv
// tb_d_flip_flop_sr_latch: directed plan plus random steps against a truth-table model
module tb_d_flip_flop_sr_latch;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] s, r, q, qn;
    logic       d, dff_q, parity_q;
    int         errors = 0;
    int         checks = 0;
    bit   [7:0] m_state;
    bit   [7:0] m_q, m_qn;
    bit         m_dff, m_par;

    d_flip_flop_sr_latch #(.NUM_LATCHES(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .s        (s),
        .r        (r),
        .d        (d),
        .q        (q),
        .qn       (qn),
        .dff_q    (dff_q),
        .parity_q (parity_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock per step: drive mid-cycle, check latches, then check registers after the edge.
    task automatic step(input bit rs, input bit [7:0] sv, input bit [7:0] rv, input bit dv);
        @(negedge clk);
        reset = rs; s = sv; r = rv; d = dv;
        #1;
        for (int i = 0; i < 8; i++) begin
            if (rs) begin
                m_state[i] = 1'b0; m_q[i] = 1'b0; m_qn[i] = 1'b1;
            end else if (sv[i] && rv[i]) begin
                m_state[i] = 1'b0; m_q[i] = 1'b0; m_qn[i] = 1'b0;
            end else begin
                if (sv[i]) m_state[i] = 1'b1;
                if (rv[i]) m_state[i] = 1'b0;
                m_q[i] = m_state[i]; m_qn[i] = !m_state[i];
            end
        end
        chk("q", q, m_q);
        chk("qn", qn, m_qn);
        @(posedge clk);
        m_dff = rs ? 1'b0 : dv;
        m_par = rs ? 1'b0 : ($countones(m_q) % 2 == 1);
        #1;
        chk("dff_q", {7'd0, dff_q}, {7'd0, m_dff});
        chk("parity_q", {7'd0, parity_q}, {7'd0, m_par});
    endtask

    initial begin
        reset = 1'b1; s = 8'h00; r = 8'h00; d = 1'b0;
        step(1, 8'hFF, 8'h00, 1);
        step(1, 8'hFF, 8'h00, 1);
        chk("reset_q", q, 8'h00);
        chk("reset_qn", qn, 8'hFF);
        step(0, 8'h05, 8'h00, 0);
        step(0, 8'h00, 8'h00, 0);
        chk("hold_q", q, 8'h05);
        chk("hold_qn", qn, 8'hFA);
        step(0, 8'h00, 8'h01, 0);
        step(0, 8'h00, 8'h00, 0);
        chk("reset_bit_q", q, 8'h04);
        step(0, 8'hFF, 8'hFF, 0);
        chk("forbid_qn", qn, 8'h00);
        step(0, 8'h00, 8'h00, 0);
        chk("release_qn", qn, 8'hFF);
        step(0, 8'h00, 8'h00, 1);
        step(0, 8'h00, 8'h00, 0);
        step(0, 8'h00, 8'h00, 1);
        step(0, 8'h00, 8'h00, 1);
        step(0, 8'h07, 8'h00, 0);
        chk("par_07", {7'd0, parity_q}, 8'h01);
        step(0, 8'h08, 8'h00, 1);
        chk("par_0f", {7'd0, parity_q}, 8'h00);
        step(0, 8'h00, 8'h00, 1);
        step(1, 8'h00, 8'h00, 1);
        chk("mid_reset_q", q, 8'h00);
        chk("mid_reset_dff", {7'd0, dff_q}, 8'h00);
        step(0, 8'h30, 8'h00, 1);
        chk("after_release_dff", {7'd0, dff_q}, 8'h01);
        for (int n = 0; n < 300; n++)
            step($urandom_range(0, 19) == 0, 8'($urandom & $urandom), 8'($urandom & $urandom),
                 1'($urandom));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
